// File: rtl/rv_timer_mc_pkg.sv
// Shared constants for the multi-compare RISC-V style timer: register offsets,
// compare-channel layout and a byte-enable merge helper.
package rv_timer_mc_pkg;

    localparam int MaxNumCmp  = 8;
    localparam int TimerWidth = 64;
    localparam int CmpStride  = 8;

    localparam logic [15:0] OffCtrl       = 16'h0000;
    localparam logic [15:0] OffPrescale   = 16'h0004;
    localparam logic [15:0] OffIntrStatus = 16'h0008;
    localparam logic [15:0] OffIntrEnable = 16'h000C;
    localparam logic [15:0] OffCmpBase    = 16'h4000;
    localparam logic [15:0] OffMtimeLo    = 16'hBFF8;
    localparam logic [15:0] OffMtimeHi    = 16'hBFFC;

    function automatic logic [31:0] merge_be32(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  be);
        logic [31:0] res;
        res = old_val;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) res[8*b +: 8] = new_val[8*b +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/rv_timer_prescaler.sv
// Prescale counter: counts 0..prescale_i while enabled and emits a one-cycle
// tick on the cycle the count matches, restarting from 0.
module rv_timer_prescaler #(
    parameter int PrescaleWidth = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     en_i,
    input  logic                     clear_i,
    input  logic [PrescaleWidth-1:0] prescale_i,
    output logic                     tick_o
);

    logic [PrescaleWidth-1:0] r_count;

    assign tick_o = en_i && (r_count == prescale_i);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_count <= '0;
        end else if (clear_i || tick_o) begin
            r_count <= '0;
        end else if (en_i) begin
            r_count <= r_count + PrescaleWidth'(1);
        end
    end

endmodule

// File: rtl/rv_timer_mc.sv
// Memory-mapped 64-bit timer with prescaler and NumCmp compare channels,
// single-cycle request/response bus and level interrupts per channel.
module rv_timer_mc
    import rv_timer_mc_pkg::*;
#(
    parameter int DataWidth     = 32,
    parameter int AddressWidth  = 32,
    parameter int NumCmp        = 4,
    parameter int PrescaleWidth = 16
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    timer_req_i,
    input  logic [AddressWidth-1:0] timer_addr_i,
    input  logic                    timer_we_i,
    input  logic [DataWidth/8-1:0]  timer_be_i,
    input  logic [DataWidth-1:0]    timer_wdata_i,
    output logic                    timer_rvalid_o,
    output logic [DataWidth-1:0]    timer_rdata_o,
    output logic                    timer_err_o,
    output logic [NumCmp-1:0]       timer_intr_o
);

    if (DataWidth != 32) begin : g_bad_dw
        $error("rv_timer_mc: DataWidth must be 32");
    end
    if (NumCmp < 1 || NumCmp > MaxNumCmp) begin : g_bad_ncmp
        $error("rv_timer_mc: NumCmp out of range");
    end
    if (PrescaleWidth < 1 || PrescaleWidth > 32) begin : g_bad_pw
        $error("rv_timer_mc: PrescaleWidth out of range");
    end

    logic                     r_en;
    logic [PrescaleWidth-1:0] r_prescale;
    logic [TimerWidth-1:0]    r_mtime;
    logic [TimerWidth-1:0]    r_mtimecmp [NumCmp];
    logic [NumCmp-1:0]        r_intr_en;
    logic [NumCmp-1:0]        r_intr;
    logic                     r_rvalid;
    logic                     r_err;
    logic [31:0]              r_rdata;

    logic [15:0]           w_off;
    logic [15:0]           w_cmp_off;
    logic                  w_is_ctrl, w_is_pre, w_is_status, w_is_ie;
    logic                  w_is_mtlo, w_is_mthi;
    logic                  w_cmp_region, w_cmp_hit, w_cmp_hi;
    logic [2:0]            w_cmp_idx;
    logic                  w_err, w_wr, w_tick;
    logic [NumCmp-1:0]     w_status;
    logic [TimerWidth-1:0] w_cmp_sel;
    logic [TimerWidth-1:0] w_mtime_inc;
    logic [31:0]           w_mtime_lo_nxt, w_mtime_hi_nxt;
    logic [31:0]           w_rdata;
    logic                  w_addr_unused;

    assign w_addr_unused = ^timer_addr_i[AddressWidth-1:16];
    assign w_off         = timer_addr_i[15:0];
    assign w_cmp_off     = w_off - OffCmpBase;

    assign w_is_ctrl    = (w_off == OffCtrl);
    assign w_is_pre     = (w_off == OffPrescale);
    assign w_is_status  = (w_off == OffIntrStatus);
    assign w_is_ie      = (w_off == OffIntrEnable);
    assign w_is_mtlo    = (w_off == OffMtimeLo);
    assign w_is_mthi    = (w_off == OffMtimeHi);
    assign w_cmp_region = (w_off >= OffCmpBase) &&
                          (w_cmp_off < 16'(CmpStride * MaxNumCmp)) &&
                          (w_cmp_off[1:0] == 2'b00);
    assign w_cmp_idx    = w_cmp_off[5:3];
    assign w_cmp_hi     = w_cmp_off[2];
    assign w_cmp_hit    = w_cmp_region && ({1'b0, w_cmp_idx} < 4'(NumCmp));

    assign w_err = !(w_is_ctrl || w_is_pre || w_is_status || w_is_ie ||
                     w_cmp_hit || w_is_mtlo || w_is_mthi) ||
                   (w_is_status && timer_we_i);
    // be == 0 is a no-op: it must not even restart the prescaler
    assign w_wr  = timer_req_i && timer_we_i && !w_err && (|timer_be_i);

    rv_timer_prescaler #(
        .PrescaleWidth(PrescaleWidth)
    ) u_prescaler (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .en_i      (r_en),
        .clear_i   (w_wr && (w_is_ctrl || w_is_pre)),
        .prescale_i(r_prescale),
        .tick_o    (w_tick)
    );

    for (genvar i = 0; i < NumCmp; i++) begin : g_cmp
        assign w_status[i] = (r_mtime >= r_mtimecmp[i]);
    end

    // Written bytes override the incremented value; carries into them are lost
    assign w_mtime_inc    = r_mtime + TimerWidth'(w_tick);
    assign w_mtime_lo_nxt = (w_wr && w_is_mtlo) ?
                            merge_be32(w_mtime_inc[31:0], timer_wdata_i, timer_be_i) :
                            w_mtime_inc[31:0];
    assign w_mtime_hi_nxt = (w_wr && w_is_mthi) ?
                            merge_be32(w_mtime_inc[63:32], timer_wdata_i, timer_be_i) :
                            w_mtime_inc[63:32];

    always_comb begin
        w_cmp_sel = '0;
        for (int i = 0; i < NumCmp; i++) begin
            if (w_cmp_idx == 3'(i)) w_cmp_sel = r_mtimecmp[i];
        end
    end

    always_comb begin
        w_rdata = '0;
        if (w_is_ctrl)        w_rdata[0] = r_en;
        else if (w_is_pre)    w_rdata = 32'(r_prescale);
        else if (w_is_status) w_rdata = 32'(w_status);
        else if (w_is_ie)     w_rdata = 32'(r_intr_en);
        else if (w_cmp_hit)   w_rdata = w_cmp_hi ? w_cmp_sel[63:32] : w_cmp_sel[31:0];
        else if (w_is_mtlo)   w_rdata = r_mtime[31:0];
        else if (w_is_mthi)   w_rdata = r_mtime[63:32];
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_en       <= 1'b1;
            r_prescale <= '0;
            r_mtime    <= '0;
            for (int i = 0; i < NumCmp; i++) r_mtimecmp[i] <= '1;
            r_intr_en  <= '1;
            r_intr     <= '0;
            r_rvalid   <= 1'b0;
            r_err      <= 1'b0;
            r_rdata    <= '0;
        end else begin
            r_mtime <= {w_mtime_hi_nxt, w_mtime_lo_nxt};
            if (w_wr && w_is_ctrl && timer_be_i[0]) r_en <= timer_wdata_i[0];
            if (w_wr && w_is_pre)
                r_prescale <= PrescaleWidth'(merge_be32(32'(r_prescale), timer_wdata_i, timer_be_i));
            if (w_wr && w_is_ie)
                r_intr_en <= NumCmp'(merge_be32(32'(r_intr_en), timer_wdata_i, timer_be_i));
            for (int i = 0; i < NumCmp; i++) begin
                if (w_wr && w_cmp_hit && (w_cmp_idx == 3'(i))) begin
                    if (w_cmp_hi)
                        r_mtimecmp[i][63:32] <= merge_be32(r_mtimecmp[i][63:32], timer_wdata_i, timer_be_i);
                    else
                        r_mtimecmp[i][31:0] <= merge_be32(r_mtimecmp[i][31:0], timer_wdata_i, timer_be_i);
                end
            end
            r_intr   <= w_status & r_intr_en;
            r_rvalid <= timer_req_i;
            r_err    <= timer_req_i && w_err;
            r_rdata  <= (timer_req_i && !timer_we_i && !w_err) ? w_rdata : '0;
        end
    end

    assign timer_rvalid_o = r_rvalid;
    assign timer_err_o    = r_err;
    assign timer_rdata_o  = r_rdata;
    assign timer_intr_o   = r_intr;

endmodule
